// File: rtl/program_sequencer.sv
// program_sequencer
// Host-side companion to the pipelined calculator core. Accepts calculator
// operations over a valid/ready stream, encodes each one into an 18-bit
// instruction word, writes the words into the core's instruction memory,
// then steps the core's Counter through the loaded program and collects
// each Result, tagged with the instruction index that produced it.
//
// Optional feature macro: RESULT_CHECKSUM_EN
//   When defined, adds the Checksum output: a running modulo-2^DATA_WIDTH
//   sum of every Out_Result delivered during the current program. It is
//   cleared on reset and on an accepted Start, and is final when Done rises.
//
// Input handshake: an operation transfers on a rising CLK edge where
// In_Valid and In_Ready are both high. In_Ready depends only on the
// registered state, never on In_Valid. The operation fields and In_Last
// are only meaningful while In_Valid is high.

module program_sequencer #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH    = 18,
    parameter int CORE_LATENCY  = 3
) (
    input  logic                     CLK,
    input  logic                     Reset_n,
    input  logic                     Start,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic                     In_Last,
    input  logic [1:0]               In_Operation,
    input  logic [7:0]               In_Operand_1,
    input  logic [7:0]               In_Operand_2,
    output logic                     Mem_Write_Enable,
    output logic [ADDRESS_WIDTH-1:0] Mem_Write_Address,
    output logic [DATA_WIDTH-1:0]    Mem_Write_Data,
    output logic [ADDRESS_WIDTH-1:0] Counter,
    input  logic [DATA_WIDTH-1:0]    Core_Result,
    output logic                     Out_Valid,
    output logic [ADDRESS_WIDTH-1:0] Out_Index,
    output logic [DATA_WIDTH-1:0]    Out_Result,
    output logic                     Busy,
    output logic                     Done,
    output logic                     Overflow_Error
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0]    Checksum
`endif
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_GAP   = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_wr_ptr;
    // One bit wider than the address so a full 2^ADDRESS_WIDTH program fits.
    logic [ADDRESS_WIDTH:0]   r_len;
    logic [ADDRESS_WIDTH-1:0] r_counter;
    logic                     r_mem_we;
    logic [ADDRESS_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0]    r_mem_data;
    logic                     r_overflow;
    logic [CORE_LATENCY-1:0]  r_sr_valid;
    logic [ADDRESS_WIDTH-1:0] r_sr_index [CORE_LATENCY];
    logic                     r_out_valid;
    logic [ADDRESS_WIDTH-1:0] r_out_index;
    logic [DATA_WIDTH-1:0]    r_out_result;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [2:0]               w_next_state;
    logic                     w_in_ready;
    logic                     w_handshake;
    logic                     w_start_ok;
    logic                     w_last_addr;
    logic                     w_load_end;
    logic                     w_run_end;
    logic                     w_sr_empty;
    logic [DATA_WIDTH-1:0]    w_enc_word;

    assign w_in_ready  = (r_state == S_LOAD);
    assign w_handshake = In_Valid & w_in_ready;
    // Start is only honoured when no load or run is in progress.
    assign w_start_ok  = Start & ((r_state == S_IDLE) | (r_state == S_DONE));
    assign w_last_addr = (r_wr_ptr == {ADDRESS_WIDTH{1'b1}});
    // A load ends on the marked final word or when memory is full.
    assign w_load_end  = w_handshake & (In_Last | w_last_addr);
    // Program length is at least one word whenever RUN is reached.
    assign w_run_end   = (r_state == S_RUN) &
                         ({1'b0, r_counter} == (r_len - 1'b1));
    assign w_sr_empty  = (r_sr_valid == '0);
    // [17:16] operation, [15:8] operand 1, [7:0] operand 2.
    assign w_enc_word  = {In_Operation, In_Operand_1, In_Operand_2};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign In_Ready          = w_in_ready;
    assign Busy              = (r_state == S_LOAD) | (r_state == S_GAP) |
                               (r_state == S_RUN)  | (r_state == S_DRAIN);
    assign Done              = (r_state == S_DONE);
    assign Mem_Write_Enable  = r_mem_we;
    assign Mem_Write_Address = r_mem_addr;
    assign Mem_Write_Data    = r_mem_data;
    assign Counter           = r_counter;
    assign Out_Valid         = r_out_valid;
    assign Out_Index         = r_out_index;
    assign Out_Result        = r_out_result;
    assign Overflow_Error    = r_overflow;

    // Next-state selection for the load / run sequence.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_next_state = S_LOAD;
            S_LOAD:  if (w_load_end) w_next_state = S_GAP;
            // One idle cycle so the final memory write commits before reading.
            S_GAP:   w_next_state = S_RUN;
            S_RUN:   if (w_run_end) w_next_state = S_DRAIN;
            // Leave once the last tracked instruction has produced Out_Valid.
            S_DRAIN: if (w_sr_empty) w_next_state = S_DONE;
            S_DONE:  if (w_start_ok) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Load path: write pointer, program length and the registered write port.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr   <= '0;
            r_len      <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            r_mem_we <= w_handshake;
            if (w_start_ok) begin
                r_wr_ptr <= '0;
                r_len    <= '0;
            end else if (w_handshake) begin
                r_mem_addr <= r_wr_ptr;
                r_mem_data <= w_enc_word;
                r_wr_ptr   <= r_wr_ptr + 1'b1;
                r_len      <= r_len + 1'b1;
            end
        end
    end

    // Sticky flag: memory filled up before a word marked In_Last arrived.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_overflow <= 1'b0;
        end else if (w_start_ok) begin
            r_overflow <= 1'b0;
        end else if (w_handshake & w_last_addr & ~In_Last) begin
            r_overflow <= 1'b1;
        end
    end

    // Read index: counts 0..length-1 during RUN, parked at 0 otherwise.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_counter <= '0;
        end else if ((r_state == S_RUN) && !w_run_end) begin
            r_counter <= r_counter + 1'b1;
        end else begin
            r_counter <= '0;
        end
    end

    // Latency-matching shift register carrying (valid, index) for each
    // Counter value so it lines up with the core's Result.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_sr_valid <= '0;
            for (int i = 0; i < CORE_LATENCY; i++) begin
                r_sr_index[i] <= '0;
            end
        end else begin
            r_sr_valid[0] <= (r_state == S_RUN);
            r_sr_index[0] <= r_counter;
            for (int i = 1; i < CORE_LATENCY; i++) begin
                r_sr_valid[i] <= r_sr_valid[i-1];
                r_sr_index[i] <= r_sr_index[i-1];
            end
        end
    end

    // Result capture; Out_Result and Out_Index hold between valid cycles.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_out_valid  <= 1'b0;
            r_out_index  <= '0;
            r_out_result <= '0;
        end else if (r_sr_valid[CORE_LATENCY-1]) begin
            r_out_valid  <= 1'b1;
            r_out_index  <= r_sr_index[CORE_LATENCY-1];
            r_out_result <= Core_Result;
        end else begin
            r_out_valid  <= 1'b0;
        end
    end

`ifdef RESULT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    assign Checksum = r_checksum;

    // Running sum of delivered results, one cycle behind Out_Valid.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_checksum <= '0;
        end else if (w_start_ok) begin
            r_checksum <= '0;
        end else if (r_out_valid) begin
            r_checksum <= r_checksum + r_out_result;
        end
    end
`else
    // No checksum accumulator in this build.
`endif

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer
// Directed bench for program_sequencer, built with ADDRESS_WIDTH=2 so that
// a four-word load reaches the memory-full condition. A small behavioural
// calculator core (instruction memory + 3-stage ALU pipeline) answers the
// sequencer's Counter. Expected writes and results are hand-computed.
// Optional macro RESULT_CHECKSUM_EN enables the Checksum checks.

module tb_program_sequencer;

    localparam int AW = 2;
    localparam int DW = 18;
    localparam int LAT = 3;

    logic          CLK;
    logic          Reset_n;
    logic          Start;
    logic          In_Valid;
    logic          In_Ready;
    logic          In_Last;
    logic [1:0]    In_Operation;
    logic [7:0]    In_Operand_1;
    logic [7:0]    In_Operand_2;
    logic          Mem_Write_Enable;
    logic [AW-1:0] Mem_Write_Address;
    logic [DW-1:0] Mem_Write_Data;
    logic [AW-1:0] Counter;
    logic [DW-1:0] Core_Result;
    logic          Out_Valid;
    logic [AW-1:0] Out_Index;
    logic [DW-1:0] Out_Result;
    logic          Busy;
    logic          Done;
    logic          Overflow_Error;
`ifdef RESULT_CHECKSUM_EN
    logic [DW-1:0] Checksum;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [DW-1:0] exp_res [4];

    program_sequencer #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .CORE_LATENCY  (LAT)
    ) dut (
        .CLK               (CLK),
        .Reset_n           (Reset_n),
        .Start             (Start),
        .In_Valid          (In_Valid),
        .In_Ready          (In_Ready),
        .In_Last           (In_Last),
        .In_Operation      (In_Operation),
        .In_Operand_1      (In_Operand_1),
        .In_Operand_2      (In_Operand_2),
        .Mem_Write_Enable  (Mem_Write_Enable),
        .Mem_Write_Address (Mem_Write_Address),
        .Mem_Write_Data    (Mem_Write_Data),
        .Counter           (Counter),
        .Core_Result       (Core_Result),
        .Out_Valid         (Out_Valid),
        .Out_Index         (Out_Index),
        .Out_Result        (Out_Result),
        .Busy              (Busy),
        .Done              (Done),
        .Overflow_Error    (Overflow_Error)
`ifdef RESULT_CHECKSUM_EN
        ,
        .Checksum          (Checksum)
`endif
    );

    // ---------------- clock ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ---------------- behavioural calculator core ----------------
    logic [DW-1:0] core_mem [4];
    logic [DW-1:0] core_p1;
    logic [DW-1:0] core_p2;

    function automatic logic [DW-1:0] alu(input logic [DW-1:0] instr);
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        a = {10'd0, instr[15:8]};
        b = {10'd0, instr[7:0]};
        case (instr[17:16])
            2'd0:    alu = a + b;
            2'd1:    alu = a - b;
            2'd2:    alu = a * b;
            default: alu = a ^ b;
        endcase
    endfunction

    // Instruction memory write port.
    always @(posedge CLK) begin
        if (Mem_Write_Enable) core_mem[Mem_Write_Address] <= Mem_Write_Data;
    end

    // Result for a Counter value appears on Core_Result three cycles later.
    always @(posedge CLK) begin
        core_p1     <= alu(core_mem[Counter]);
        core_p2     <= core_p1;
        Core_Result <= core_p2;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        tick();
        Start = 1'b0;
    endtask

    // Offer one operation, expect it accepted and written at exp_addr.
    task automatic send(input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic last,
                        input logic [AW-1:0] exp_addr,
                        input logic [DW-1:0] exp_data);
        chk("in_ready_load", In_Ready, 1);
        In_Valid     = 1'b1;
        In_Operation = op;
        In_Operand_1 = a;
        In_Operand_2 = b;
        In_Last      = last;
        tick();
        In_Valid = 1'b0;
        In_Last  = 1'b0;
        chk("wr_en", Mem_Write_Enable, 1);
        chk($sformatf("wr_addr_%0d", exp_addr), Mem_Write_Address, exp_addr);
        chk($sformatf("wr_data_%0d", exp_addr), Mem_Write_Data, exp_data);
    endtask

    // Called in the GAP cycle; walks RUN, DRAIN and the first DONE cycle.
    task automatic run_check(input int n, input logic poke_start);
        logic exp_v;
        chk("gap_in_ready", In_Ready, 0);
        chk("gap_counter", Counter, 0);
        chk("gap_busy", Busy, 1);
        for (int k = 1; k <= n + 5; k++) begin
            tick();
            chk($sformatf("counter_k%0d", k), Counter,
                (k - 1 < n) ? 32'(k - 1) : 32'd0);
            exp_v = (k >= 5) && (k <= 4 + n);
            chk($sformatf("out_valid_k%0d", k), Out_Valid, exp_v);
            if (exp_v) begin
                chk($sformatf("out_index_k%0d", k), Out_Index, k - 5);
                chk($sformatf("out_result_k%0d", k), Out_Result, exp_res[k-5]);
            end
            chk($sformatf("done_k%0d", k), Done, (k == n + 5));
            chk($sformatf("busy_k%0d", k), Busy, (k < n + 5));
            Start = poke_start && (k == 2);
        end
        Start = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int ov_count;
        int busy_count;

        Reset_n      = 1'b0;
        Start        = 1'b0;
        In_Valid     = 1'b0;
        In_Last      = 1'b0;
        In_Operation = '0;
        In_Operand_1 = '0;
        In_Operand_2 = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_in_ready", In_Ready, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_counter", Counter, 0);
        chk("rst_out_valid", Out_Valid, 0);
        chk("rst_wr_en", Mem_Write_Enable, 0);
        chk("rst_overflow", Overflow_Error, 0);
        #3 Reset_n = 1'b1;
        tick();
        chk("idle_in_ready", In_Ready, 0);

        // Program 1: three words, two idle cycles after the first,
        // with a Start during LOAD that must be ignored.
        pulse_start();
        chk("load_busy", Busy, 1);
        chk("load_done", Done, 0);
        send(2'd0, 8'd5, 8'd3, 1'b0, 2'd0, 18'h00503);
        Start = 1'b1;
        tick();
        Start = 1'b0;
        chk("gap1_wr_en", Mem_Write_Enable, 0);
        tick();
        chk("gap2_wr_en", Mem_Write_Enable, 0);
        send(2'd1, 8'd9, 8'd4, 1'b0, 2'd1, 18'h10904);
        send(2'd2, 8'd6, 8'd7, 1'b1, 2'd2, 18'h20607);
        exp_res[0] = 18'd8;
        exp_res[1] = 18'd5;
        exp_res[2] = 18'd42;
        exp_res[3] = 18'd0;
        run_check(3, 1'b1);
        chk("p1_overflow", Overflow_Error, 0);
`ifdef RESULT_CHECKSUM_EN
        chk("p1_checksum", Checksum, 55);
`endif
        tick();
        chk("hold_done", Done, 1);
        chk("hold_out_result", Out_Result, 42);
        chk("hold_out_valid", Out_Valid, 0);

        // Program 2: four words without In_Last fill the memory.
        pulse_start();
        chk("p2_done_clr", Done, 0);
        chk("p2_busy", Busy, 1);
`ifdef RESULT_CHECKSUM_EN
        chk("p2_checksum_clr", Checksum, 0);
`endif
        send(2'd0, 8'h01, 8'h02, 1'b0, 2'd0, 18'h00102);
        send(2'd3, 8'hF0, 8'h0F, 1'b0, 2'd1, 18'h3F00F);
        send(2'd1, 8'h03, 8'h05, 1'b0, 2'd2, 18'h10305);
        send(2'd2, 8'hFF, 8'hFF, 1'b0, 2'd3, 18'h2FFFF);
        chk("p2_overflow", Overflow_Error, 1);
        exp_res[0] = 18'h00003;
        exp_res[1] = 18'h000FF;
        exp_res[2] = 18'h3FFFE;
        exp_res[3] = 18'h0FE01;
        run_check(4, 1'b0);
        chk("p2_overflow_done", Overflow_Error, 1);
`ifdef RESULT_CHECKSUM_EN
        chk("p2_checksum", Checksum, 18'h0FF01);
`endif

        // Program 3: restart clears overflow; reset in the middle of RUN.
        pulse_start();
        chk("p3_overflow_clr", Overflow_Error, 0);
        send(2'd0, 8'd2, 8'd2, 1'b0, 2'd0, 18'h00202);
        send(2'd0, 8'd3, 8'd3, 1'b1, 2'd1, 18'h00303);
        tick();
        tick();
        chk("p3_counter_run", Counter, 1);
        chk("p3_busy_run", Busy, 1);
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_counter", Counter, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_done", Done, 0);
        chk("mid_rst_in_ready", In_Ready, 0);
        chk("mid_rst_wr_en", Mem_Write_Enable, 0);
        chk("mid_rst_wr_addr", Mem_Write_Address, 0);
        chk("mid_rst_wr_data", Mem_Write_Data, 0);
        chk("mid_rst_out_valid", Out_Valid, 0);
        chk("mid_rst_out_index", Out_Index, 0);
        chk("mid_rst_out_result", Out_Result, 0);
        chk("mid_rst_overflow", Overflow_Error, 0);
        #3 Reset_n = 1'b1;
        ov_count   = 0;
        busy_count = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (Out_Valid) ov_count++;
            if (Busy) busy_count++;
        end
        chk("post_rst_out_valids", ov_count, 0);
        chk("post_rst_busy_cycles", busy_count, 0);
        chk("post_rst_counter", Counter, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
